id_stage: RTL and testbench

//  Instruction-decode stage feeding the EXE/ALU block: decodes a 32-bit MIPS-subset word, reads

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/id_stage_if.sv | 37 +++
 rtl/reg_file.sv | 35 +++
 rtl/id_stage.sv | 127 ++++++++++++
 tb/tb_id_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU codes, opcode/funct values and the ID/EX bundle
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_e           alu_op;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              illegal;
    } id_ex_t;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch/writeback inputs and ID/EX outputs of the decode stage
interface id_stage_if;
    import mips_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [3:0]        ALU_operation;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              illegal;

    modport master (
        output in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, A, B, ALU_operation, store_data, dest,
               reg_write, mem_read, mem_write, branch, illegal
    );

    modport slave (
        input  in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, A, B, ALU_operation, store_data, dest,
               reg_write, mem_read, mem_write, branch, illegal
    );

endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R/1W register file, x0 hard-wired to zero, write-through on read
module reg_file #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle writeback is forwarded so decode never sees the stale value
    assign o_rdata_a = (i_raddr_a == '0)                   ? '0      :
                       (i_we && i_waddr == i_raddr_a)      ? i_wdata :
                                                             r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0)                   ? '0      :
                       (i_we && i_waddr == i_raddr_b)      ? i_wdata :
                                                             r_regs[i_raddr_b];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS-subset decode with register read and ID/EX output register
module id_stage
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);
    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_in_ready;
    logic              w_xfer;
    id_ex_t            w_dec;
    id_ex_t            r_out;
    logic              r_out_valid;

    assign w_opcode = bus.instr[31:26];
    assign w_rs     = bus.instr[25:21];
    assign w_rt     = bus.instr[20:16];
    assign w_rd     = bus.instr[15:11];
    assign w_imm    = bus.instr[15:0];
    assign w_funct  = bus.instr[5:0];

    reg_file #(.NREGS(NREGS), .DATA_W(DATA_W), .AW(REG_AW)) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_rs),
        .o_rdata_a (w_rs_val),
        .i_raddr_b (w_rt),
        .o_rdata_b (w_rt_val)
    );

    always_comb begin
        w_dec            = '0;
        w_dec.a          = w_rs_val;
        w_dec.b          = w_rt_val;
        w_dec.store_data = w_rt_val;
        w_dec.alu_op     = ALU_AND;
        case (w_opcode)
            OP_RTYPE: begin
                w_dec.dest      = w_rd;
                w_dec.reg_write = 1'b1;
                case (w_funct)
                    FN_ADD:  w_dec.alu_op = ALU_ADD;
                    FN_SUB:  w_dec.alu_op = ALU_SUB;
                    FN_AND:  w_dec.alu_op = ALU_AND;
                    FN_OR:   w_dec.alu_op = ALU_OR;
                    FN_NOR:  w_dec.alu_op = ALU_NOR;
                    FN_SLT:  w_dec.alu_op = ALU_SLT;
                    default: begin
                        w_dec.dest      = '0;
                        w_dec.reg_write = 1'b0;
                        w_dec.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                w_dec.alu_op    = (w_opcode == OP_ADDI) ? ALU_ADD : ALU_SLT;
                w_dec.b         = sext16(w_imm);
                w_dec.dest      = w_rt;
                w_dec.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                w_dec.alu_op    = (w_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                w_dec.b         = {{(DATA_W-16){1'b0}}, w_imm};
                w_dec.dest      = w_rt;
                w_dec.reg_write = 1'b1;
            end
            OP_LW: begin
                w_dec.alu_op    = ALU_ADD;
                w_dec.b         = sext16(w_imm);
                w_dec.dest      = w_rt;
                w_dec.mem_read  = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OP_SW: begin
                w_dec.alu_op    = ALU_ADD;
                w_dec.b         = sext16(w_imm);
                w_dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_dec.alu_op = ALU_SUB;
                w_dec.branch = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // A flush blocks acceptance so a killed slot can never be refilled in the same edge
    assign w_in_ready = !bus.flush && (!r_out_valid || bus.out_ready);
    assign w_xfer     = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            if (w_xfer) r_out <= w_dec;
            if (bus.flush)          r_out_valid <= 1'b0;
            else if (w_xfer)        r_out_valid <= 1'b1;
            else if (bus.out_ready) r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.A             = r_out.a;
    assign bus.B             = r_out.b;
    assign bus.ALU_operation = r_out.alu_op;
    assign bus.store_data    = r_out.store_data;
    assign bus.dest          = r_out.dest;
    assign bus.reg_write     = r_out.reg_write;
    assign bus.mem_read      = r_out.mem_read;
    assign bus.mem_write     = r_out.mem_write;
    assign bus.branch        = r_out.branch;
    assign bus.illegal       = r_out.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized and directed checks of id_stage against a reference model
module tb_id_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_if bus();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]  mrf [32];
    logic         exp_valid = 1'b0;
    logic [109:0] exp_f = '0;
    logic [109:0] exp_m = '1;
    logic         smp_ready;
    logic         exp_ready;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [110:0] obs();
        return {bus.out_valid, bus.A, bus.B, bus.ALU_operation, bus.store_data, bus.dest,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.illegal};
    endfunction

    function automatic logic [31:0] rdv(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wa == idx) return wd;
        return mrf[idx];
    endfunction

    // Expected ID/EX fields for one instruction, plus a mask of the fields that are defined
    function automatic void predict(input logic [31:0] ins, input logic [31:0] rsv,
                                    input logic [31:0] rtv,
                                    output logic [109:0] f, output logic [109:0] m);
        logic [31:0] a, b, sd, sx, zx;
        logic [3:0]  op;
        logic [4:0]  d;
        logic        rw, mr, mw, br, il;
        a = rsv; b = rtv; sd = rtv; op = 4'h0; d = 5'd0;
        rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; il = 1'b0;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        case (ins[31:26])
            6'h00: begin
                d = ins[15:11]; rw = 1'b1;
                case (ins[5:0])
                    6'h20: op = 4'h2;
                    6'h22: op = 4'h6;
                    6'h24: op = 4'h0;
                    6'h25: op = 4'h1;
                    6'h27: op = 4'hC;
                    6'h2A: op = 4'h7;
                    default: begin il = 1'b1; rw = 1'b0; end
                endcase
            end
            6'h08: begin op = 4'h2; b = sx; d = ins[20:16]; rw = 1'b1; end
            6'h0A: begin op = 4'h7; b = sx; d = ins[20:16]; rw = 1'b1; end
            6'h0C: begin op = 4'h0; b = zx; d = ins[20:16]; rw = 1'b1; end
            6'h0D: begin op = 4'h1; b = zx; d = ins[20:16]; rw = 1'b1; end
            6'h23: begin op = 4'h2; b = sx; d = ins[20:16]; rw = 1'b1; mr = 1'b1; end
            6'h2B: begin op = 4'h2; b = sx; mw = 1'b1; end
            6'h04: begin op = 4'h6; br = 1'b1; end
            default: il = 1'b1;
        endcase
        f = {a, b, op, sd, d, rw, mr, mw, br, il};
        m = {il ? 32'h0 : 32'hFFFF_FFFF, il ? 32'h0 : 32'hFFFF_FFFF, 4'hF,
             mw ? 32'hFFFF_FFFF : 32'h0, rw ? 5'h1F : 5'h00, 5'h1F};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 14))
            0:  return mk_r(rs, rt, rd, 6'h20);
            1:  return mk_r(rs, rt, rd, 6'h22);
            2:  return mk_r(rs, rt, rd, 6'h24);
            3:  return mk_r(rs, rt, rd, 6'h25);
            4:  return mk_r(rs, rt, rd, 6'h27);
            5:  return mk_r(rs, rt, rd, 6'h2A);
            6:  return mk_i(6'h08, rs, rt, imm);
            7:  return mk_i(6'h0A, rs, rt, imm);
            8:  return mk_i(6'h0C, rs, rt, imm);
            9:  return mk_i(6'h0D, rs, rt, imm);
            10: return mk_i(6'h23, rs, rt, imm);
            11: return mk_i(6'h2B, rs, rt, imm);
            12: return mk_i(6'h04, rs, rt, imm);
            13: return mk_r(rs, rt, rd, 6'($urandom_range(0, 31)));
            default: return {6'h3F, 26'($urandom)};
        endcase
    endfunction

    // Drive one cycle of inputs, sample in_ready before the edge, advance the model at the edge
    task automatic apply(input logic r, input logic iv, input logic [31:0] ins,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ordy);
        logic xfer;
        logic [109:0] pf, pm;
        rst = r; bus.in_valid = iv; bus.instr = ins; bus.flush = fl;
        bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd; bus.out_ready = ordy;
        exp_ready = !fl && (!exp_valid || ordy);
        xfer = iv && exp_ready;
        predict(ins, rdv(ins[25:21], we, wa, wd), rdv(ins[20:16], we, wa, wd), pf, pm);
        #3 smp_ready = bus.in_ready;
        @(posedge clk);
        #1;
        if (r) begin
            exp_valid = 1'b0; exp_f = '0; exp_m = '1;
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else begin
            if (fl)        exp_valid = 1'b0;
            else if (xfer) exp_valid = 1'b1;
            else if (ordy) exp_valid = 1'b0;
            if (xfer) begin exp_f = pf; exp_m = pm; end
            if (we && wa != 5'd0) mrf[wa] = wd;
        end
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs() !== 111'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", obs());
        end
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if (smp_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", smp_ready);
        end
    endtask

    task automatic test_add();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b1);
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd2, 32'd3, 1'b1);
        apply(1'b0, 1'b1, 32'h0022_1820, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if ({bus.out_valid, bus.A, bus.B, bus.ALU_operation, bus.dest, bus.reg_write} !==
            {1'b1, 32'd5, 32'd3, 4'b0010, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL add_x3 got v=%b A=%h B=%h op=%h d=%0d rw=%b want 1 5 3 2 3 1",
                     bus.out_valid, bus.A, bus.B, bus.ALU_operation, bus.dest, bus.reg_write);
        end
    endtask

    task automatic test_bypass();
        apply(1'b0, 1'b1, 32'h0080_2822, 1'b0, 1'b1, 5'd4, 32'h0000_DEAD, 1'b1);
        n_cmp++;
        if ({bus.out_valid, bus.A, bus.ALU_operation} !== {1'b1, 32'h0000_DEAD, 4'b0110}) begin
            n_fail++;
            $display("FAIL bypass got v=%b A=%h op=%h want 1 0000dead 6",
                     bus.out_valid, bus.A, bus.ALU_operation);
        end
    endtask

    task automatic test_imm();
        logic [31:0] prog [5];
        apply(1'b0, 1'b1, 32'h2006_FFFF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if ({bus.B, bus.ALU_operation, bus.dest} !== {32'hFFFF_FFFF, 4'b0010, 5'd6}) begin
            n_fail++; $display("FAIL addi_sext got B=%h op=%h want ffffffff 2", bus.B, bus.ALU_operation);
        end
        apply(1'b0, 1'b1, 32'h3406_FFFF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if ({bus.B, bus.ALU_operation} !== {32'h0000_FFFF, 4'b0001}) begin
            n_fail++; $display("FAIL ori_zext got B=%h op=%h want 0000ffff 1", bus.B, bus.ALU_operation);
        end
        prog = '{32'h8C27_0004, 32'hAC22_FFF8, 32'h1022_0003, 32'h2825_8000, 32'h3025_8001};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, prog[i], 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
            n_cmp++;
            if ((obs() & {1'b1, exp_m}) !== ({exp_valid, exp_f} & {1'b1, exp_m})) begin
                n_fail++; $display("FAIL imm_prog[%0d] got %h want %h", i, obs(), {exp_valid, exp_f});
            end
        end
        n_cmp++;
        if (bus.A !== 32'd5) begin
            n_fail++; $display("FAIL andi_rs got A=%h want 5", bus.A);
        end
    endtask

    task automatic test_backpressure();
        logic [110:0] snap;
        apply(1'b0, 1'b1, mk_r(5'd1, 5'd2, 5'd7, 6'h25), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        snap = obs();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, gen_instr(), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            n_cmp++;
            if (smp_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, smp_ready);
            end
            n_cmp++;
            if (obs() !== snap) begin
                n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, obs(), snap);
            end
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, gen_instr(), 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
            n_cmp++;
            if (smp_ready !== 1'b1 ||
                (obs() & {1'b1, exp_m}) !== ({exp_valid, exp_f} & {1'b1, exp_m})) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got rdy=%b %h want rdy=1 %h",
                         i, smp_ready, obs(), {exp_valid, exp_f});
            end
        end
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        apply(1'b0, 1'b1, mk_r(5'd1, 5'd2, 5'd8, 6'h2A), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        apply(1'b0, 1'b1, mk_r(5'd2, 5'd1, 5'd9, 6'h20), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        n_cmp++;
        if (smp_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush got rdy=%b v=%b want 0 0", smp_ready, bus.out_valid);
        end
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs() !== {exp_valid, exp_f}) begin
            n_fail++; $display("FAIL flush_no_accept got %h want %h", obs(), {exp_valid, exp_f});
        end
        apply(1'b0, 1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if ({bus.out_valid, bus.illegal, bus.reg_write, bus.mem_read, bus.mem_write,
             bus.branch, bus.ALU_operation} !== {1'b1, 1'b1, 4'b0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL illegal got v=%b il=%b rw=%b mr=%b mw=%b br=%b op=%h want 1 1 0 0 0 0 0",
                     bus.out_valid, bus.illegal, bus.reg_write, bus.mem_read, bus.mem_write,
                     bus.branch, bus.ALU_operation);
        end
    endtask

    task automatic test_x0();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd0, 32'd7, 1'b1);
        apply(1'b0, 1'b1, 32'h0000_0820, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_cmp++;
        if ({bus.out_valid, bus.A, bus.B} !== {1'b1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL x0_write got v=%b A=%h B=%h want 1 0 0", bus.out_valid, bus.A, bus.B);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(1'b0, ($urandom % 4) != 0, gen_instr(), ($urandom % 10) == 0,
                  ($urandom % 2) != 0, 5'($urandom_range(0, 7)), $urandom, ($urandom % 4) != 0);
            n_cmp++;
            if (smp_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", i, smp_ready, exp_ready);
            end
            n_cmp++;
            if ((obs() & {1'b1, exp_m}) !== ({exp_valid, exp_f} & {1'b1, exp_m})) begin
                n_fail++; $display("FAIL rand_out[%0d] got %h want %h", i, obs(), {exp_valid, exp_f});
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++)
            apply(1'b0, 1'b1, gen_instr(), 1'b0, 1'b1, 5'($urandom_range(1, 7)), $urandom, 1'b0);
        apply(1'b1, 1'b1, gen_instr(), 1'b0, 1'b1, 5'd3, $urandom, 1'b1);
        n_cmp++;
        if (obs() !== 111'd0) begin
            n_fail++; $display("FAIL mid_reset got %h want 0", obs());
        end
        for (int i = 1; i < 8; i++) begin
            apply(1'b0, 1'b1, mk_r(5'(i), 5'(i + 1), 5'd9, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
            n_cmp++;
            if ({bus.out_valid, bus.A, bus.B} !== {1'b1, 32'd0, 32'd0}) begin
                n_fail++;
                $display("FAIL rf_cleared[%0d] got v=%b A=%h B=%h want 1 0 0", i, bus.out_valid, bus.A, bus.B);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        bus.in_valid = 1'b0; bus.instr = 32'd0; bus.flush = 1'b0; bus.wb_en = 1'b0;
        bus.wb_addr = 5'd0; bus.wb_data = 32'd0; bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_bypass();
        test_imm();
        test_backpressure();
        test_flush();
        test_x0();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
